// File: rtl/rv32_fetch_unit_pkg.sv
// Shared constants for the RV32 fetch stage: PC step, NOP encoding
// and the bit layout of a queued {pc, inst} entry.
package rv32_fetch_unit_pkg;

    localparam int unsigned PC_INC = 4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Queue entry layout: pc in [XLEN+31:32], inst in [31:0]
    localparam int unsigned INST_W = 32;
    localparam int unsigned ENT_INST_LSB = 0;
    localparam int unsigned ENT_PC_LSB = 32;

endpackage

// File: rtl/rv32_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, instruction handshake
// to the consumer, redirect/halt inputs and status flags.
// master = fetch unit side, slave = memory/consumer side.
interface rv32_fetch_unit_if #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               inst_valid;
    logic [31:0]        inst;
    logic [XLEN-1:0]    inst_pc;
    logic               inst_ready;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_target;
    logic               halt;
    logic               halted;
    logic               misaligned;

    modport master (
        output imem_addr,
        input  imem_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_target, halt,
        output halted, misaligned
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_target, halt,
        input  halted, misaligned
    );
endinterface

// File: rtl/rv32_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
// Ports: push/pop/flush controls, wdata in, combinational head rdata,
// full/empty status. Flush overrides push and pop.
module rv32_fetch_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // When full, a push only fits if the head leaves this cycle
    assign do_push = push & (~full | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 instruction-fetch stage: PC register, imem read, fetch queue,
// redirect and sticky halt. Ports: clk, reset (async, active-high),
// bus (rv32_fetch_unit_if.master). Optional FETCH_MISALIGN_TRAP_EN
// turns misaligned redirects into a halting trap.
module rv32_fetch_unit
    import rv32_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4,
    parameter int              IMEM_AW  = 6
) (
    input logic               clk,
    input logic               reset,
    rv32_fetch_unit_if.master bus
);
    localparam int ENT_W = XLEN + INST_W;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             halted_q, halted_d;
    logic             push, pop, flush;
    logic             q_full, q_empty;
    logic [ENT_W-1:0] q_head;
    logic [XLEN-1:0]  tgt;
    logic             bad_tgt;

    assign tgt = bus.redirect_target & ~XLEN'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign bad_tgt = |bus.redirect_target[1:0];
    assign bus.misaligned = mis_q;
`else
    assign bad_tgt = 1'b0;
    assign bus.misaligned = 1'b0;
`endif

    assign pop = ~q_empty & bus.inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        push       = 1'b0;
        flush      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d = mis_q;
`endif
        if (halted_q) begin
            // Frozen until reset
        end else if (bus.halt) begin
            halted_d = 1'b1;
            flush    = 1'b1;
        end else if (bus.redirect_valid) begin
            flush = 1'b1;
            if (bad_tgt) begin
                halted_d = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                mis_d = 1'b1;
`endif
            end else begin
                fetch_pc_d = tgt;
            end
        end else if (!q_full || pop) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q <= mis_d;
`endif
        end
    end

    rv32_fetch_queue #(
        .W     (ENT_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({fetch_pc_q, bus.imem_data}),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign bus.imem_addr  = fetch_pc_q[IMEM_AW+1:2];
    assign bus.halted     = halted_q;
    assign bus.inst_valid = ~q_empty;
    assign bus.inst    = q_empty ? '0 : q_head[ENT_INST_LSB +: INST_W];
    assign bus.inst_pc = q_empty ? '0 : q_head[ENT_PC_LSB +: XLEN];

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Randomized self-checking bench for rv32_fetch_unit against a
// transaction-level model (queue of {pc, inst} plus a PC variable).
module tb_rv32_fetch_unit;

    localparam int QD = 4;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] mem [64];

    rv32_fetch_unit_if #(.XLEN(32), .IMEM_AW(6)) bus ();

    rv32_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .QDEPTH   (QD),
        .IMEM_AW  (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t mq[$];
    logic [31:0] m_pc;
    logic m_halted, m_mis;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic v;
        v = (mq.size() > 0);
        chk("inst_valid", 64'(bus.inst_valid), 64'(v));
        chk("inst", 64'(bus.inst), v ? 64'(mq[0].inst) : 64'd0);
        chk("inst_pc", 64'(bus.inst_pc), v ? 64'(mq[0].pc) : 64'd0);
        chk("imem_addr", 64'(bus.imem_addr), 64'((m_pc >> 2) % 64));
        chk("halted", 64'(bus.halted), 64'(m_halted));
        chk("misaligned", 64'(bus.misaligned), 64'(m_mis));
    endtask

    function automatic void model_reset();
        mq.delete();
        m_pc     = 32'h0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
    endfunction

    // One clock of behaviour as described by the fetch rules
    function automatic void model_step(bit rdy, bit rv,
                                       logic [31:0] t, bit h);
        bit popped;
        ent_t e;
        if (m_halted) return;
        popped = rdy && (mq.size() > 0);
        if (h) begin
            m_halted = 1'b1;
            mq.delete();
        end else if (rv) begin
            mq.delete();
            if (TRAP_EN && (t % 4 != 0)) begin
                m_halted = 1'b1;
                m_mis    = 1'b1;
            end else begin
                m_pc = t - (t % 4);
            end
        end else begin
            if (popped) void'(mq.pop_front());
            if (mq.size() < QD) begin
                e.pc   = m_pc;
                e.inst = mem[(m_pc >> 2) % 64];
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    // Called at a falling edge: check, drive, advance model, wait
    task automatic cycle(bit rdy, bit rv, logic [31:0] t, bit h);
        check_all();
        bus.inst_ready      = rdy;
        bus.redirect_valid  = rv;
        bus.redirect_target = t;
        bus.halt            = h;
        model_step(rdy, rv, t, h);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.halt           = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.halt            = 1'b0;
        for (int k = 0; k < 64; k++) mem[k] = k;
        @(negedge clk);

        // Streaming after reset, no bubbles
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0);

        // Stall with full queue, then drain
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        chk("stall_addr", 64'(bus.imem_addr), 64'd4);
        chk("stall_head", 64'(bus.inst_pc), 64'h0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);

        // Redirect while popping head at 0x8
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("pre_redir_pc", 64'(bus.inst_pc), 64'h8);
        cycle(1, 1, 32'h40, 0);
        chk("redir_bubble", 64'(bus.inst_valid), 64'd0);
        chk("redir_addr", 64'(bus.imem_addr), 64'h10);
        cycle(1, 0, 0, 0);
        chk("redir_pc", 64'(bus.inst_pc), 64'h40);
        cycle(1, 0, 0, 0);

        // Halt together with redirect
        cycle(1, 1, 32'h80, 1);
        for (int i = 0; i < 6; i++) cycle(i[0], i[1], 32'h20, 0);
        chk("halt_sticky", 64'(bus.halted), 64'd1);
        chk("halt_addr", 64'(bus.imem_addr), 64'h12);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);

        // Misaligned redirect
        cycle(1, 1, 32'h42, 0);
        cycle(1, 0, 0, 0);
        if (TRAP_EN) begin
            chk("mis_flag", 64'(bus.misaligned), 64'd1);
            chk("mis_halt", 64'(bus.halted), 64'd1);
        end else begin
            chk("mis_align_pc", 64'(bus.inst_pc), 64'h40);
        end
        do_reset();

        // Word-address wrap
        cycle(1, 1, 32'hFC, 0);
        chk("wrap_addr63", 64'(bus.imem_addr), 64'd63);
        cycle(1, 0, 0, 0);
        chk("wrap_pc_fc", 64'(bus.inst_pc), 64'hFC);
        chk("wrap_addr0", 64'(bus.imem_addr), 64'd0);
        cycle(1, 0, 0, 0);
        chk("wrap_pc_100", 64'(bus.inst_pc), 64'h100);

        // Randomized traffic
        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            int r;
            bit rdy, rv, h;
            r = $urandom_range(0, 9);
            if (r == 0)      t = $urandom;
            else if (r == 1) t = 32'hFFFF_FFF8;
            else             t = $urandom & 32'h0000_03FC;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            h   = ($urandom_range(0, 99) == 0);
            if ((m_halted && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 299) == 0)
                do_reset();
            else
                cycle(rdy, rv, t, h);
        end
        check_all();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
